// File: rtl/openhw_ahb_narb.sv
// Multi-requester AHB-Lite arbiter. It supports fixed-priority or round-robin ownership
// and burst locking, and keeps one saved address phase per requester.
module openhw_ahb_narb #(
  parameter int NREQ    = 3,
  parameter int PA_BITS = 32,
  parameter int AHBW    = 64,
  parameter bit RR      = 1'b1
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [2*NREQ-1:0]       ReqHTRANS,
  input  logic [NREQ-1:0]         ReqHWRITE,
  input  logic [3*NREQ-1:0]       ReqHSIZE,
  input  logic [3*NREQ-1:0]       ReqHBURST,
  input  logic [PA_BITS*NREQ-1:0] ReqHADDR,
  input  logic [AHBW*NREQ-1:0]    ReqHWDATA,
  input  logic [AHBW/8*NREQ-1:0]  ReqHWSTRB,
  output logic [NREQ-1:0]         ReqHREADY,
  output logic [NREQ-1:0]         ReqHRESP,
  input  logic                    HREADY,
  input  logic                    HRESP,
  output logic [PA_BITS-1:0]      HADDR,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [1:0]              HTRANS,
  output logic [AHBW-1:0]         HWDATA,
  output logic [AHBW/8-1:0]       HWSTRB,
  output logic [3:0]              HPROT,
  output logic                    HMASTLOCK,
  output logic [NREQ-1:0]         Grant
);
  localparam int OW = $clog2(NREQ);
  localparam int SW = AHBW / 8;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;

  logic [NREQ-1:0]    saved_valid_r, saved_write_r;
  logic [2:0]         saved_size_r  [NREQ];
  logic [2:0]         saved_burst_r [NREQ];
  logic [PA_BITS-1:0] saved_addr_r  [NREQ];
  logic [OW-1:0]      owner_r, last_grant_r, data_owner_r;
  logic               locked_r, wait_q_r, data_valid_r;
  logic [3:0]         beat_cnt_r;

  logic [NREQ-1:0]    grant_s, dgrant_s, pending_s, capture_s, restore_s;
  logic [1:0]         eff_trans_s [NREQ];
  logic               eff_write_s [NREQ];
  logic [2:0]         eff_size_s  [NREQ];
  logic [2:0]         eff_burst_s [NREQ];
  logic [PA_BITS-1:0] eff_addr_s  [NREQ];
  logic [OW-1:0]      owner_nxt_s, last_nxt_s;
  logic               locked_nxt_s, accept_s, accept_nonseq_s;
  logic [3:0]         beat_nxt_s;

  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_beats = 4'd3;
      3'b100, 3'b101: burst_beats = 4'd7;
      3'b110, 3'b111: burst_beats = 4'd15;
      default:        burst_beats = 4'd0;
    endcase
  endfunction

  // Rotating the doubled request vector puts the search start at bit 0.
  function automatic logic [OW-1:0] arbitrate(input logic [NREQ-1:0] req,
                                              input logic [OW-1:0] last,
                                              input logic [OW-1:0] park);
    logic [OW-1:0]     start, pick, cand;
    logic [2*NREQ-1:0] dbl;
    logic [OW:0]       sum;
    logic              found, hit;
    start = RR ? ((last == OW'(NREQ-1)) ? '0 : last + OW'(1)) : '0;
    dbl   = {req, req} >> start;
    pick  = park;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      hit   = !found && dbl[k];
      sum   = {1'b0, start} + (OW+1)'(k);
      cand  = (sum >= (OW+1)'(NREQ)) ? OW'(sum - (OW+1)'(NREQ)) : OW'(sum);
      pick  = hit ? cand : pick;
      found = found | hit;
    end
    return pick;
  endfunction

  assign grant_s   = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
  assign dgrant_s  = {{(NREQ-1){1'b0}}, 1'b1} << data_owner_r;
  assign Grant     = grant_s;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  // Per-requester effective phase, capture/restore strobes and returned handshakes
  always_comb begin
    pending_s = '0;
    capture_s = '0;
    restore_s = '0;
    ReqHREADY = '0;
    ReqHRESP  = '0;
    for (int i = 0; i < NREQ; i++) begin
      eff_trans_s[i] = saved_valid_r[i] ? NONSEQ : ReqHTRANS[2*i +: 2];
      eff_write_s[i] = saved_valid_r[i] ? saved_write_r[i] : ReqHWRITE[i];
      eff_size_s[i]  = saved_valid_r[i] ? saved_size_r[i] : ReqHSIZE[3*i +: 3];
      eff_burst_s[i] = saved_valid_r[i] ? saved_burst_r[i] : ReqHBURST[3*i +: 3];
      eff_addr_s[i]  = saved_valid_r[i] ? saved_addr_r[i] : ReqHADDR[PA_BITS*i +: PA_BITS];
      pending_s[i]   = saved_valid_r[i] | (ReqHTRANS[2*i +: 2] == NONSEQ);
      capture_s[i]   = (ReqHTRANS[2*i +: 2] == NONSEQ) & HREADY & ~grant_s[i] & ~saved_valid_r[i];
      restore_s[i]   = grant_s[i] & HREADY & saved_valid_r[i];
      ReqHREADY[i]   = HREADY & ~saved_valid_r[i];
      ReqHRESP[i]    = HRESP & data_valid_r & dgrant_s[i];
    end
  end

  // Manager-port address phase from the owner and data from the data-phase owner
  always_comb begin
    HTRANS = '0;
    HWRITE = 1'b0;
    HSIZE  = '0;
    HBURST = '0;
    HADDR  = '0;
    HWDATA = '0;
    HWSTRB = '0;
    for (int i = 0; i < NREQ; i++) begin
      HTRANS = HTRANS | ({2{grant_s[i]}} & eff_trans_s[i]);
      HWRITE = HWRITE | (grant_s[i] & eff_write_s[i]);
      HSIZE  = HSIZE  | ({3{grant_s[i]}} & eff_size_s[i]);
      HBURST = HBURST | ({3{grant_s[i]}} & eff_burst_s[i]);
      HADDR  = HADDR  | ({PA_BITS{grant_s[i]}} & eff_addr_s[i]);
      HWDATA = HWDATA | ({AHBW{dgrant_s[i]}} & ReqHWDATA[AHBW*i +: AHBW]);
      HWSTRB = HWSTRB | ({SW{dgrant_s[i]}} & ReqHWSTRB[SW*i +: SW]);
    end
  end

  // Burst lock tracking and next-owner selection
  always_comb begin
    accept_nonseq_s = HREADY && (HTRANS == NONSEQ);
    accept_s        = HREADY && ((HTRANS == NONSEQ) || (HTRANS == SEQ));
    locked_nxt_s    = locked_r;
    beat_nxt_s      = beat_cnt_r;
    if (accept_nonseq_s) begin
      locked_nxt_s = (HBURST != SINGLE);
      beat_nxt_s   = burst_beats(HBURST);
    end else if (locked_r && (HTRANS == IDLE)) begin
      locked_nxt_s = 1'b0;
      beat_nxt_s   = 4'd0;
    end else if (locked_r && HREADY && (HTRANS == SEQ) && (beat_cnt_r != 4'd0)) begin
      locked_nxt_s = (beat_cnt_r != 4'd1);
      beat_nxt_s   = beat_cnt_r - 4'd1;
    end else begin
      locked_nxt_s = locked_r;
      beat_nxt_s   = beat_cnt_r;
    end
    last_nxt_s = accept_nonseq_s ? owner_r : last_grant_r;
    if (!HREADY || wait_q_r || locked_nxt_s) begin
      owner_nxt_s = owner_r;
    end else begin
      owner_nxt_s = arbitrate(pending_s, last_nxt_s, owner_r);
    end
  end

  // Saved address phases: load on capture, drop once the granted phase is accepted
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      saved_valid_r <= '0;
      saved_write_r <= '0;
      for (int i = 0; i < NREQ; i++) begin
        saved_size_r[i]  <= 3'd0;
        saved_burst_r[i] <= 3'd0;
        saved_addr_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (capture_s[i]) begin
          saved_valid_r[i] <= 1'b1;
          saved_write_r[i] <= ReqHWRITE[i];
          saved_size_r[i]  <= ReqHSIZE[3*i +: 3];
          saved_burst_r[i] <= ReqHBURST[3*i +: 3];
          saved_addr_r[i]  <= ReqHADDR[PA_BITS*i +: PA_BITS];
        end else if (restore_s[i]) begin
          saved_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Ownership, lock and data-phase registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_r      <= '0;
      last_grant_r <= OW'(NREQ-1);
      locked_r     <= 1'b0;
      beat_cnt_r   <= 4'd0;
      wait_q_r     <= 1'b0;
      data_owner_r <= '0;
      data_valid_r <= 1'b0;
    end else begin
      owner_r      <= owner_nxt_s;
      last_grant_r <= last_nxt_s;
      locked_r     <= locked_nxt_s;
      beat_cnt_r   <= beat_nxt_s;
      wait_q_r     <= ~HREADY;
      if (HREADY) begin
        data_owner_r <= owner_r;
        data_valid_r <= accept_s;
      end
    end
  end
endmodule

// File: tb/tb_openhw_ahb_narb.sv
// Directed bench for openhw_ahb_narb: a round-robin instance and a fixed-priority
// instance share one set of requester stimulus.
module tb_openhw_ahb_narb;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE  = 3'b000;
  localparam logic [2:0] B_INCR4   = 3'b011;
  localparam logic [2:0] B_INCR8   = 3'b101;

  logic        HCLK, HRESETn, HREADY, HRESP;
  logic [5:0]  ReqHTRANS;
  logic [2:0]  ReqHWRITE;
  logic [8:0]  ReqHSIZE, ReqHBURST;
  logic [95:0] ReqHADDR;
  logic [191:0] ReqHWDATA;
  logic [23:0] ReqHWSTRB;

  logic [2:0]  ReqHREADY, ReqHRESP, Grant;
  logic [31:0] HADDR;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic [63:0] HWDATA;
  logic [7:0]  HWSTRB;
  logic [3:0]  HPROT;

  logic [2:0]  ReqHREADY_fp, ReqHRESP_fp, Grant_fp;
  logic [31:0] HADDR_fp;
  logic        HWRITE_fp, HMASTLOCK_fp;
  logic [2:0]  HSIZE_fp, HBURST_fp;
  logic [1:0]  HTRANS_fp;
  logic [63:0] HWDATA_fp;
  logic [7:0]  HWSTRB_fp;
  logic [3:0]  HPROT_fp;

  int checks = 0;
  int errors = 0;

  openhw_ahb_narb #(.NREQ(3), .PA_BITS(32), .AHBW(64), .RR(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ReqHTRANS(ReqHTRANS), .ReqHWRITE(ReqHWRITE),
    .ReqHSIZE(ReqHSIZE), .ReqHBURST(ReqHBURST), .ReqHADDR(ReqHADDR),
    .ReqHWDATA(ReqHWDATA), .ReqHWSTRB(ReqHWSTRB), .ReqHREADY(ReqHREADY),
    .ReqHRESP(ReqHRESP), .HREADY(HREADY), .HRESP(HRESP), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .Grant(Grant)
  );

  openhw_ahb_narb #(.NREQ(3), .PA_BITS(32), .AHBW(64), .RR(1'b0)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .ReqHTRANS(ReqHTRANS), .ReqHWRITE(ReqHWRITE),
    .ReqHSIZE(ReqHSIZE), .ReqHBURST(ReqHBURST), .ReqHADDR(ReqHADDR),
    .ReqHWDATA(ReqHWDATA), .ReqHWSTRB(ReqHWSTRB), .ReqHREADY(ReqHREADY_fp),
    .ReqHRESP(ReqHRESP_fp), .HREADY(HREADY), .HRESP(HRESP), .HADDR(HADDR_fp),
    .HWRITE(HWRITE_fp), .HSIZE(HSIZE_fp), .HBURST(HBURST_fp), .HTRANS(HTRANS_fp),
    .HWDATA(HWDATA_fp), .HWSTRB(HWSTRB_fp), .HPROT(HPROT_fp), .HMASTLOCK(HMASTLOCK_fp),
    .Grant(Grant_fp)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] tr, input logic wr,
                         input logic [2:0] bu, input logic [31:0] ad);
    ReqHTRANS[2*i +: 2] = tr;
    ReqHWRITE[i]        = wr;
    ReqHSIZE[3*i +: 3]  = 3'b011;
    ReqHBURST[3*i +: 3] = bu;
    ReqHADDR[32*i +: 32] = ad;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) set_req(i, TR_IDLE, 1'b0, B_SINGLE, 32'h0);
  endtask

  task automatic next_cycle();
    @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    ReqHWDATA = 192'h0;
    ReqHWSTRB = 24'h0;
    idle_all();

    // Reset state
    next_cycle(); #1;
    check("rst_grant", Grant, 3'b001);
    check("rst_hready", ReqHREADY, 3'b111);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_hprot", HPROT, 4'b0011);
    check("rst_mastlock", HMASTLOCK, 1'b0);

    // Test 1: Req0 and Req2 together, Req2 captured and replayed
    next_cycle(); HRESETn = 1'b1;
    set_req(0, TR_NONSEQ, 1'b0, B_SINGLE, 32'h100);
    set_req(2, TR_NONSEQ, 1'b1, B_SINGLE, 32'h200); #1;
    check("t1_c0_grant", Grant, 3'b001);
    check("t1_c0_haddr", HADDR, 32'h100);
    check("t1_c0_rdy", ReqHREADY, 3'b111);
    next_cycle();
    set_req(0, TR_IDLE, 1'b0, B_SINGLE, 32'h0);
    set_req(2, TR_IDLE, 1'b1, B_SINGLE, 32'h0BAD); #1;
    check("t1_c1_grant", Grant, 3'b100);
    check("t1_c1_haddr", HADDR, 32'h200);
    check("t1_c1_htrans", HTRANS, 2'b10);
    check("t1_c1_hwrite", HWRITE, 1'b1);
    check("t1_c1_rdy", ReqHREADY, 3'b011);
    next_cycle(); idle_all(); #1;
    check("t1_c2_rdy", ReqHREADY, 3'b111);
    check("t1_c2_htrans", HTRANS, 2'b00);

    // Test 2: Req1 INCR4 holds the bus against Req0
    next_cycle();
    set_req(1, TR_NONSEQ, 1'b0, B_INCR4, 32'h1000); #1;
    check("t2_c3_grant", Grant, 3'b100);
    next_cycle();
    set_req(1, TR_SEQ, 1'b0, B_INCR4, 32'h1008);
    set_req(0, TR_NONSEQ, 1'b0, B_SINGLE, 32'h300); #1;
    check("t2_b0_grant", Grant, 3'b010);
    check("t2_b0_haddr", HADDR, 32'h1000);
    check("t2_b0_hburst", HBURST, B_INCR4);
    check("t2_b0_rdy", ReqHREADY, 3'b101);
    next_cycle();
    set_req(0, TR_IDLE, 1'b0, B_SINGLE, 32'h0); #1;
    check("t2_b1_haddr", HADDR, 32'h1008);
    check("t2_b1_htrans", HTRANS, 2'b11);
    check("t2_b1_rdy", ReqHREADY, 3'b110);
    next_cycle();
    set_req(1, TR_SEQ, 1'b0, B_INCR4, 32'h1010); #1;
    check("t2_b2_grant", Grant, 3'b010);
    check("t2_b2_haddr", HADDR, 32'h1010);
    next_cycle();
    set_req(1, TR_SEQ, 1'b0, B_INCR4, 32'h1018); #1;
    check("t2_b3_grant", Grant, 3'b010);
    check("t2_b3_haddr", HADDR, 32'h1018);
    next_cycle();
    set_req(1, TR_IDLE, 1'b0, B_SINGLE, 32'h0); #1;
    check("t2_c5_grant", Grant, 3'b001);
    check("t2_c5_haddr", HADDR, 32'h300);
    check("t2_c5_htrans", HTRANS, 2'b10);

    // Test 3: three wait states during Req2 address phase
    next_cycle();
    set_req(2, TR_NONSEQ, 1'b1, B_SINGLE, 32'h2000); #1;
    check("t3_pre_rdy", ReqHREADY, 3'b111);
    next_cycle();
    HREADY = 1'b0;
    set_req(2, TR_IDLE, 1'b0, B_SINGLE, 32'h0);
    set_req(0, TR_NONSEQ, 1'b0, B_SINGLE, 32'h400);
    for (int w = 0; w < 3; w++) begin
      if (w > 0) next_cycle();
      #1;
      check("t3_wait_grant", Grant, 3'b100);
      check("t3_wait_haddr", HADDR, 32'h2000);
      check("t3_wait_rdy", ReqHREADY, 3'b000);
    end
    next_cycle(); HREADY = 1'b1; #1;
    check("t3_go_grant", Grant, 3'b100);
    check("t3_go_haddr", HADDR, 32'h2000);
    check("t3_go_rdy", ReqHREADY, 3'b011);
    next_cycle();
    set_req(0, TR_IDLE, 1'b0, B_SINGLE, 32'h0); #1;
    check("t3_post_grant", Grant, 3'b100);
    check("t3_post_rdy", ReqHREADY, 3'b110);

    // Test 5: Req0 read then Req1 write; data and HRESP routing
    next_cycle();
    ReqHWDATA = {64'h2222_2222_2222_2222, 64'hDEAD_BEEF_CAFE_F00D, 64'h1111_1111_1111_1111};
    ReqHWSTRB = {8'hF0, 8'hFF, 8'h0F};
    set_req(1, TR_NONSEQ, 1'b1, B_SINGLE, 32'h500); #1;
    check("t5_a0_grant", Grant, 3'b001);
    check("t5_a0_haddr", HADDR, 32'h400);
    check("t5_a0_hwrite", HWRITE, 1'b0);
    next_cycle();
    HRESP = 1'b1;
    set_req(1, TR_IDLE, 1'b0, B_SINGLE, 32'h0); #1;
    check("t5_a1_grant", Grant, 3'b010);
    check("t5_a1_hwrite", HWRITE, 1'b1);
    check("t5_d0_hwdata", HWDATA, 64'h1111_1111_1111_1111);
    check("t5_d0_hwstrb", HWSTRB, 8'h0F);
    check("t5_d0_resp", ReqHRESP, 3'b001);
    next_cycle(); #1;
    check("t5_d1_hwdata", HWDATA, 64'hDEAD_BEEF_CAFE_F00D);
    check("t5_d1_hwstrb", HWSTRB, 8'hFF);
    check("t5_d1_resp", ReqHRESP, 3'b010);
    next_cycle(); #1;
    check("t5_d2_resp", ReqHRESP, 3'b000);
    HRESP = 1'b0;

    // Test 4: continuous SINGLE requests, round-robin vs fixed priority
    next_cycle(); HRESETn = 1'b0;
    next_cycle(); HRESETn = 1'b1;
    set_req(0, TR_NONSEQ, 1'b0, B_SINGLE, 32'hA000);
    set_req(1, TR_NONSEQ, 1'b0, B_SINGLE, 32'hB000);
    set_req(2, TR_NONSEQ, 1'b0, B_SINGLE, 32'hC000); #1;
    check("t4_d0_rr", Grant, 3'b001);
    check("t4_d0_fp", Grant_fp, 3'b001);
    next_cycle(); #1;
    check("t4_d1_rr", Grant, 3'b010);
    check("t4_d1_haddr", HADDR, 32'hB000);
    check("t4_d1_rr_rdy", ReqHREADY, 3'b001);
    check("t4_d1_fp", Grant_fp, 3'b001);
    next_cycle(); #1;
    check("t4_d2_rr", Grant, 3'b100);
    check("t4_d2_haddr", HADDR, 32'hC000);
    check("t4_d2_fp", Grant_fp, 3'b001);
    check("t4_d2_fp_rdy", ReqHREADY_fp, 3'b001);
    next_cycle(); #1;
    check("t4_d3_rr", Grant, 3'b001);
    check("t4_d3_fp", Grant_fp, 3'b001);

    // Test 6: async reset in the middle of an INCR8 with Req2 saved
    next_cycle(); idle_all();
    next_cycle();
    next_cycle(); #1;
    check("t6_idle_grant", Grant, 3'b100);
    check("t6_idle_rdy", ReqHREADY, 3'b111);
    set_req(1, TR_NONSEQ, 1'b0, B_INCR8, 32'h3000);
    next_cycle();
    set_req(1, TR_SEQ, 1'b0, B_INCR8, 32'h3008);
    set_req(2, TR_NONSEQ, 1'b0, B_SINGLE, 32'h5000); #1;
    check("t6_b0_grant", Grant, 3'b010);
    check("t6_b0_hburst", HBURST, B_INCR8);
    next_cycle();
    set_req(2, TR_IDLE, 1'b0, B_SINGLE, 32'h0); #1;
    check("t6_b1_grant", Grant, 3'b010);
    check("t6_b1_haddr", HADDR, 32'h3008);
    check("t6_b1_rdy", ReqHREADY, 3'b011);
    #1 HRESETn = 1'b0;
    #1;
    check("t6_rst_grant", Grant, 3'b001);
    check("t6_rst_rdy", ReqHREADY, 3'b111);
    check("t6_rst_htrans", HTRANS, 2'b00);
    next_cycle();
    HRESETn = 1'b1;
    set_req(1, TR_IDLE, 1'b0, B_SINGLE, 32'h0);
    set_req(2, TR_NONSEQ, 1'b0, B_SINGLE, 32'h6000); #1;
    check("t6_f0_grant", Grant, 3'b001);
    check("t6_f0_rdy", ReqHREADY, 3'b111);
    next_cycle();
    set_req(2, TR_IDLE, 1'b0, B_SINGLE, 32'h0); #1;
    check("t6_f1_grant", Grant, 3'b100);
    check("t6_f1_haddr", HADDR, 32'h6000);
    check("t6_f1_htrans", HTRANS, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
